// File: rtl/spi_bus_bridge.sv
// spi_bus_bridge: converts SPI-core data strobes into request/acknowledge
// transactions on an 8-bit-data, 24-bit-address internal bus, returns read
// data to the SPI transmit path and builds the SPI status byte.
module spi_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic [23:0] address,
  input  logic        we,
  input  logic        spi_busy,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [23:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic        bus_ack,
  input  logic [7:0]  bus_rdata,
  output logic [7:0]  spi_status
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  state_t     state_next;

  logic       busy_meta;
  logic       busy_s;
  logic       busy_q;
  logic       busy_rise;

  logic [7:0] tmo_cnt;
  logic       tmo_expire;

  logic       sticky_timeout;
  logic       sticky_overrun;
  logic       sticky_abort;
  logic       set_timeout;
  logic       set_overrun;
  logic       set_abort;

  // Expiry only counts when no acknowledge arrives in the same cycle.
  assign tmo_expire  = (state == REQ) && (tmo_cnt == TMO_LAST);
  assign busy_rise   = busy_s & ~busy_q;
  assign set_timeout = tmo_expire && !bus_ack;
  assign set_overrun = rx_valid && (state != IDLE);
  assign set_abort   = (state == RESP) && !busy_s;

  // Two-flop synchroniser for spi_busy plus a delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every clocked assignment is non-blocking so all flops update from
    // the same pre-edge values regardless of statement order.
    if (rst) begin
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      busy_meta <= spi_busy;
      busy_s    <= busy_meta;
      busy_q    <= busy_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: one bus cycle per accepted strobe, reads detour via RESP.
  always_comb begin
    // NOTE: the default assignment up front keeps this block free of latches
    // on paths that do not mention state_next.
    state_next = state;
    case (state)
      IDLE: if (rx_valid) state_next = REQ;
      REQ:  if (bus_ack || tmo_expire) state_next = bus_we ? IDLE : RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; reset forces IDLE so bus_req drops at once.
  always_comb begin
    bus_req  = (state == REQ);
    tx_valid = (state == RESP) && busy_s;
  end

  // Bus request fields and timeout counter, loaded when a strobe is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_addr  <= 24'h0;
      bus_we    <= 1'b0;
      bus_wdata <= 8'h00;
      tmo_cnt   <= 8'h00;
    end else begin
      if (state == IDLE && rx_valid) begin
        bus_addr  <= address;
        bus_we    <= we;
        bus_wdata <= rx_data;
        tmo_cnt   <= 8'h00;
      end else if (state == REQ) begin
        tmo_cnt <= tmo_cnt + 8'h01;
      end
    end
  end

  // Read return data: bus data on acknowledge, 8'hEE filler on timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data <= 8'h00;
    end else if (state == REQ && !bus_we) begin
      if (bus_ack)         tx_data <= bus_rdata;
      else if (tmo_expire) tx_data <= 8'hEE;
    end
  end

  // Sticky status bits: cleared after a busy_s rising edge, new events win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_timeout <= 1'b0;
      sticky_overrun <= 1'b0;
      sticky_abort   <= 1'b0;
    end else begin
      sticky_timeout <= set_timeout | (sticky_timeout & ~busy_rise);
      sticky_overrun <= set_overrun | (sticky_overrun & ~busy_rise);
      sticky_abort   <= set_abort   | (sticky_abort   & ~busy_rise);
    end
  end

  assign spi_status = {4'b0000, sticky_abort, bus_req, sticky_overrun, sticky_timeout};

endmodule

// File: tb/tb_spi_bus_bridge.sv
// tb_spi_bus_bridge: directed scenarios with literal expectations followed by
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_spi_bus_bridge;

  localparam int T    = 8;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [23:0] address = 24'h0;
  logic        we = 1'b0;
  logic        spi_busy = 1'b0;
  logic        bus_ack = 1'b0;
  logic [7:0]  bus_rdata = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        bus_req;
  logic        bus_we;
  logic [23:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  spi_status;

  always #5 clk = ~clk;

  spi_bus_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .address    (address),
    .we         (we),
    .spi_busy   (spi_busy),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .spi_status (spi_status)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one record for the accepted transaction, with
  // its request window [t_start+1, t_end] worked out when it is accepted.
  typedef struct packed {
    int          cyc;
    int          last_rst;
    bit          act;
    bit          t_read;
    bit          t_ackd;
    int          t_start;
    int          t_end;
    int          ack_cycle;
    logic [7:0]  t_rdata;
    logic        m_we;
    logic [23:0] m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_tx;
    bit          s_to;
    bit          s_ov;
    bit          s_ab;
  } model_t;

  model_t m = '0;
  bit     busy_hist [MAXC];
  int     force_d  = 0;
  int     force_rd = -1;
  bit     noise_en = 1'b0;

  // Synchronised busy as seen in cycle c: spi_busy from two cycles earlier,
  // zero while that sample predates the last reset.
  function automatic bit bs(input model_t s, input int c);
    if (c < 2 || c - 2 <= s.last_rst) return 1'b0;
    return busy_hist[(c - 2) % MAXC];
  endfunction

  function automatic model_t step(input model_t s, input bit r, input bit rv,
                                  input bit w, input logic [23:0] a, input logic [7:0] wd);
    model_t n;
    int     c;
    int     d;
    bit     b, clr, to, ov, ab;
    n = s;
    c = s.cyc;
    if (r) begin
      n = '0;
      n.last_rst  = c;
      n.ack_cycle = -1;
    end else begin
      b   = bs(s, c);
      clr = b && !bs(s, c - 1);
      to  = 1'b0;
      ov  = 1'b0;
      ab  = 1'b0;
      if (s.act && c == s.t_end) begin
        if (s.t_read) n.m_tx = s.t_ackd ? s.t_rdata : 8'hEE;
        if (!s.t_ackd) to = 1'b1;
      end
      if (s.act && s.t_read && c == s.t_end + 1 && !b) ab = 1'b1;
      if (s.act && c >= (s.t_read ? s.t_end + 2 : s.t_end + 1)) n.act = 1'b0;
      if (rv) begin
        if (n.act) begin
          ov = 1'b1;
        end else begin
          d = (force_d != 0) ? force_d : int'($urandom_range(1, T + 2));
          n.act       = 1'b1;
          n.t_start   = c;
          n.t_read    = !w;
          n.m_we      = w;
          n.m_addr    = a;
          n.m_wdata   = wd;
          n.t_ackd    = (d <= T);
          n.t_end     = c + (n.t_ackd ? d : T);
          n.ack_cycle = n.t_ackd ? c + d : -1;
          n.t_rdata   = (force_rd >= 0) ? 8'(force_rd) : 8'($urandom);
        end
      end
      n.s_to = to | (s.s_to & !clr);
      n.s_ov = ov | (s.s_ov & !clr);
      n.s_ab = ab | (s.s_ab & !clr);
    end
    n.cyc = c + 1;
    return n;
  endfunction

  // Advance the model once per clock from the inputs of the ending cycle.
  always @(posedge clk) begin
    busy_hist[m.cyc % MAXC] <= spi_busy;
    m <= step(m, rst, rx_valid, we, address, rx_data);
  end

  function automatic bit in_req_window(input model_t s);
    return s.act && s.cyc >= s.t_start + 1 && s.cyc <= s.t_end;
  endfunction

  // Bus responder: acknowledges on the planned cycle, optional stray acks
  // only while no request can be outstanding.
  initial forever begin
    @(posedge clk);
    #1;
    if (m.ack_cycle >= 0 && m.cyc == m.ack_cycle) begin
      bus_ack   = 1'b1;
      bus_rdata = m.t_rdata;
    end else begin
      bus_ack   = noise_en && !in_req_window(m) && ($urandom_range(0, 3) == 0);
      bus_rdata = 8'($urandom);
    end
  end

  // Every-cycle comparison against the model.
  int tx_seen   = 0;
  int req_rises = 0;
  bit prev_req  = 1'b0;

  initial forever begin
    logic        e_req, e_tx, e_we;
    logic [7:0]  e_txd, e_wd, e_st;
    logic [23:0] e_addr;
    @(negedge clk);
    if (rst) begin
      e_req = 0; e_tx = 0; e_txd = 0; e_we = 0; e_addr = 0; e_wd = 0; e_st = 0;
    end else begin
      e_req  = in_req_window(m);
      e_tx   = m.act && m.t_read && m.cyc == m.t_end + 1 && bs(m, m.cyc);
      e_txd  = m.m_tx;
      e_we   = m.m_we;
      e_addr = m.m_addr;
      e_wd   = m.m_wdata;
      e_st   = {4'b0000, m.s_ab, e_req, m.s_ov, m.s_to};
    end
    check("bus_req",    32'(bus_req),    32'(e_req));
    check("tx_valid",   32'(tx_valid),   32'(e_tx));
    check("tx_data",    32'(tx_data),    32'(e_txd));
    check("bus_we",     32'(bus_we),     32'(e_we));
    check("bus_addr",   32'(bus_addr),   32'(e_addr));
    check("bus_wdata",  32'(bus_wdata),  32'(e_wd));
    check("spi_status", 32'(spi_status), 32'(e_st));
    if (tx_valid === 1'b1) tx_seen++;
    if (bus_req === 1'b1 && !prev_req) req_rises++;
    prev_req = (bus_req === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  // Drop and restore spi_busy so the next busy_s rise clears the sticky bits.
  task automatic busy_cycle();
    spi_busy = 1'b0;
    repeat (4) tick();
    spi_busy = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    int tx0, rise0, req_cnt;
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx0, rise0, req_cnt;
    repeat (3) tick();
    look();
    check("reset_status", 32'(spi_status), 32'h00);
    check("reset_req", 32'(bus_req), 32'h0);
    tick();
    rst = 1'b0;
    spi_busy = 1'b1;
    repeat (4) tick();

    // Write, acknowledged in the second request cycle.
    tx0 = tx_seen;
    rx_valid = 1; we = 1; address = 24'h001234; rx_data = 8'hA5; force_d = 2;
    look();
    tick();
    rx_valid = 0; force_d = 0; we = 1'($urandom); address = 24'($urandom); rx_data = 8'($urandom);
    look();
    check("wr_req_c1", 32'(bus_req), 32'h1);
    check("wr_we", 32'(bus_we), 32'h1);
    check("wr_addr", 32'(bus_addr), 32'h001234);
    check("wr_wdata", 32'(bus_wdata), 32'hA5);
    tick(); look();
    check("wr_req_c2", 32'(bus_req), 32'h1);
    tick(); look();
    check("wr_req_off", 32'(bus_req), 32'h0);
    check("wr_status", 32'(spi_status), 32'h00);
    check("wr_no_tx", 32'(tx_seen - tx0), 32'h0);
    repeat (2) tick();

    // Read, acknowledged in the first request cycle.
    rx_valid = 1; we = 0; address = 24'h000010; force_d = 1; force_rd = 8'h3C;
    look();
    tick();
    rx_valid = 0; force_d = 0; force_rd = -1;
    look();
    check("rd_req", 32'(bus_req), 32'h1);
    check("rd_tx_early", 32'(tx_valid), 32'h0);
    tick(); look();
    check("rd_tx_valid", 32'(tx_valid), 32'h1);
    check("rd_tx_data", 32'(tx_data), 32'h3C);
    check("rd_req_off", 32'(bus_req), 32'h0);
    tick(); look();
    check("rd_tx_once", 32'(tx_valid), 32'h0);
    check("rd_tx_hold", 32'(tx_data), 32'h3C);
    repeat (2) tick();

    // Read timeout, no acknowledge.
    rx_valid = 1; we = 0; address = 24'h00ABCD; force_d = T + 1;
    look();
    tick();
    rx_valid = 0; force_d = 0;
    req_cnt = 0;
    for (int i = 1; i <= T; i++) begin
      look();
      if (bus_req === 1'b1) req_cnt++;
      tick();
    end
    look();
    check("to_req_cycles", 32'(req_cnt), 32'(T));
    check("to_req_off", 32'(bus_req), 32'h0);
    check("to_tx_valid", 32'(tx_valid), 32'h1);
    check("to_tx_data", 32'(tx_data), 32'hEE);
    tick(); look();
    check("to_status", 32'(spi_status), 32'h01);
    spi_busy = 1'b0;
    repeat (4) tick();
    look();
    check("to_sticky_hold", 32'(spi_status), 32'h01);
    spi_busy = 1'b1;
    repeat (4) tick();
    look();
    check("to_cleared", 32'(spi_status), 32'h00);
    tick();

    // Overrun: second strobe while the first read is pending.
    rise0 = req_rises; tx0 = tx_seen;
    rx_valid = 1; we = 0; address = 24'h000020; force_d = 4; force_rd = 8'h5A;
    look();
    tick();
    rx_valid = 0; force_d = 0; force_rd = -1;
    tick();
    rx_valid = 1; we = 1; address = 24'h0000FF; rx_data = 8'h11;
    look();
    tick();
    rx_valid = 0;
    look();
    check("ov_addr_kept", 32'(bus_addr), 32'h000020);
    check("ov_we_kept", 32'(bus_we), 32'h0);
    check("ov_status", 32'(spi_status), 32'h06);
    tick(); look();
    tick(); look();
    check("ov_tx_valid", 32'(tx_valid), 32'h1);
    check("ov_tx_data", 32'(tx_data), 32'h5A);
    check("ov_status_after", 32'(spi_status), 32'h02);
    repeat (4) tick();
    look();
    check("ov_one_txn", 32'(req_rises - rise0), 32'h1);
    check("ov_one_tx", 32'(tx_seen - tx0), 32'h1);
    busy_cycle();

    // Acknowledge on the expiry cycle.
    rx_valid = 1; we = 0; address = 24'h000030; force_d = T; force_rd = 8'h77;
    look();
    tick();
    rx_valid = 0; force_d = 0; force_rd = -1;
    repeat (T - 1) tick();
    look();
    check("exp_req_last", 32'(bus_req), 32'h1);
    tick(); look();
    check("exp_tx_valid", 32'(tx_valid), 32'h1);
    check("exp_tx_data", 32'(tx_data), 32'h77);
    check("exp_status", 32'(spi_status), 32'h00);
    repeat (2) tick();

    // Reset while a request is outstanding.
    rx_valid = 1; we = 0; address = 24'h00BEEF; force_d = T + 1;
    look();
    tick();
    rx_valid = 0; force_d = 0;
    tick(); look();
    check("rst_pre_req", 32'(bus_req), 32'h1);
    tick();
    rst = 1'b1;
    #1;
    check("rst_req_async", 32'(bus_req), 32'h0);
    check("rst_addr", 32'(bus_addr), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_status", 32'(spi_status), 32'h00);
    tick(); tick();
    rst = 1'b0;
    tx0 = tx_seen;
    repeat (T + 4) tick();
    look();
    check("rst_no_tx", 32'(tx_seen - tx0), 32'h0);
    check("rst_req_idle", 32'(bus_req), 32'h0);
    tick();

    // Randomized traffic with wandering spi_busy and stray acknowledges.
    noise_en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      rx_valid = ($urandom_range(0, 2) == 0);
      we       = 1'($urandom);
      address  = 24'($urandom);
      rx_data  = 8'($urandom);
      if ($urandom_range(0, 24) == 0) spi_busy = ~spi_busy;
      tick();
    end
    rx_valid = 1'b0;
    noise_en = 1'b0;
    spi_busy = 1'b1;
    repeat (20) tick();
    look();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
